// File: rtl/aibnd_str_reg.sv
// Strength-code register: scan/parallel staging register, committed to the active code with a fixed settle/ack handshake.
// Optional AIBND_STR_REG_PARITY_EN adds a registered even-parity output q_par.
module aibnd_str_reg #(
   parameter int WIDTH      = 8,
   parameter int SETTLE_CYC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             se_n,
   input  logic             si,
   output logic             so,
   input  logic             code_valid,
   input  logic [WIDTH-1:0] d,
   input  logic             upd_req,
   output logic             upd_ack,
   output logic             busy,
   output logic [WIDTH-1:0] q
`ifdef AIBND_STR_REG_PARITY_EN
   ,
   output logic             q_par
`endif
);

   localparam int CW = $clog2(SETTLE_CYC + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, ACK} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] stg_reg, stg_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             commit;

   // Scan shifting outranks the parallel load strobe.
   always_comb begin
      stg_next = stg_reg;
      if (!se_n)
         stg_next = {stg_reg[WIDTH-2:0], si};
      else if (code_valid)
         stg_next = d;
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      commit     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (upd_req) begin
               commit     = 1'b1;
               cnt_next   = CW'(SETTLE_CYC - 1);
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            // Counter holds at zero on the exit edge so it never wraps.
            if (cnt_reg == '0)
               state_next = ACK;
            else
               cnt_next = cnt_reg - CW'(1);
         end
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Commit captures the pre-edge staging value, so a same-edge load is kept for the next commit.
   assign q_next = commit ? stg_reg : q_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         stg_reg   <= '0;
         q_reg     <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         stg_reg   <= stg_next;
         q_reg     <= q_next;
         cnt_reg   <= cnt_next;
      end
   end

`ifdef AIBND_STR_REG_PARITY_EN
   logic q_par_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q_par_reg <= 1'b0;
      else if (commit)
         q_par_reg <= ^stg_reg;
   end

   assign q_par = q_par_reg;
`endif

   assign so      = stg_reg[WIDTH-1];
   assign q       = q_reg;
   assign busy    = (state_reg != IDLE);
   assign upd_ack = (state_reg == ACK);

endmodule

// File: tb/tb_aibnd_str_reg.sv
// Scoreboard bench for aibnd_str_reg: stimulus queues expected per-cycle outputs and acknowledged codes,
// a negedge monitor pops and compares them.
module tb_aibnd_str_reg;

   logic       clk;
   logic       rst;
   logic       se_n;
   logic       si;
   logic       so;
   logic       code_valid;
   logic [7:0] d;
   logic       upd_req;
   logic       upd_ack;
   logic       busy;
   logic [7:0] q;
`ifdef AIBND_STR_REG_PARITY_EN
   logic       q_par;
`endif

   aibnd_str_reg #(.WIDTH(8), .SETTLE_CYC(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .se_n       (se_n),
      .si         (si),
      .so         (so),
      .code_valid (code_valid),
      .d          (d),
      .upd_req    (upd_req),
      .upd_ack    (upd_ack),
      .busy       (busy),
      .q          (q)
`ifdef AIBND_STR_REG_PARITY_EN
      ,
      .q_par      (q_par)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic [7:0] q;
      logic       b;
      logic       a;
      logic       s;
      logic       chk_so;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] ack_q[$];
   int         total = 0;
   int         bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // Inputs are set by the caller before the edge; the expectation describes the state after it.
   task automatic step(input string nm, input logic [7:0] eq, input logic eb, input logic ea,
                       input logic es, input logic cs);
      exp_t e;
      @(posedge clk);
      #1;
      e.nm = nm; e.q = eq; e.b = eb; e.a = ea; e.s = es; e.chk_so = cs;
      sb.push_back(e);
   endtask

   task automatic settle_tail(input string nm, input logic [7:0] v);
      repeat (3) step(nm, v, 1'b1, 1'b0, 1'b0, 1'b0);
      step({nm, "_ack"}, v, 1'b1, 1'b1, 1'b0, 1'b0);
      step({nm, "_idle"}, v, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic load_commit(input string nm, input logic [7:0] v, input logic [7:0] q_before);
      code_valid = 1'b1; d = v;
      step({nm, "_load"}, q_before, 1'b0, 1'b0, 1'b0, 1'b0);
      code_valid = 1'b0; upd_req = 1'b1;
      ack_q.push_back(v);
      step({nm, "_commit"}, v, 1'b1, 1'b0, 1'b0, 1'b0);
      upd_req = 1'b0;
      settle_tail(nm, v);
   endtask

   // Monitor: per-cycle scoreboard entries plus an acknowledged-code queue popped on each upd_ack.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.nm, ".q"}, 64'(q), 64'(e.q));
            chk({e.nm, ".busy"}, 64'(busy), 64'(e.b));
            chk({e.nm, ".ack"}, 64'(upd_ack), 64'(e.a));
            if (e.chk_so) chk({e.nm, ".so"}, 64'(so), 64'(e.s));
`ifdef AIBND_STR_REG_PARITY_EN
            chk({e.nm, ".q_par"}, 64'(q_par), 64'(^e.q));
`endif
         end
         if (upd_ack) begin
            if (ack_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_ack got=1 want=0 q=%0h", q);
            end else begin
               chk("ack_code", 64'(q), 64'(ack_q.pop_front()));
            end
         end
      end
   end

   initial begin
      logic [7:0] pat;
      logic [7:0] sh;
      rst = 1'b1; se_n = 1'b1; si = 1'b0; code_valid = 1'b0; d = 8'h00; upd_req = 1'b0;
      #2;
      chk("rst.q", 64'(q), 64'h0);
      chk("rst.busy", 64'(busy), 64'h0);
      chk("rst.ack", 64'(upd_ack), 64'h0);
      chk("rst.so", 64'(so), 64'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Scan in 8'hA5 MSB-first, then shift it out with zeros.
      pat = 8'hA5;
      se_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         si = pat[7-i];
         step("scan_in", 8'h00, 1'b0, 1'b0, (i == 7) ? pat[7] : 1'b0, 1'b1);
      end
      si = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         sh = pat << j;
         step("scan_out", 8'h00, 1'b0, 1'b0, sh[7], 1'b1);
      end
      se_n = 1'b1;

      // Commit 8'h3C, with a re-request at n+2 against stg=8'hFF that must be ignored.
      code_valid = 1'b1; d = 8'h3C;
      step("load_3c", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      code_valid = 1'b0; upd_req = 1'b1;
      ack_q.push_back(8'h3C);
      step("commit_3c", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      upd_req = 1'b0; code_valid = 1'b1; d = 8'hFF;
      step("settle_ld_ff", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
      code_valid = 1'b0; upd_req = 1'b1;
      step("reissue", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      upd_req = 1'b0;
      step("settle_3c", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      step("ack_3c", 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
      step("idle_3c", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

      // Held request with a same-edge load: commits FF, keeps 5A, re-accepts after ACK.
      upd_req = 1'b1; code_valid = 1'b1; d = 8'h5A;
      ack_q.push_back(8'hFF);
      step("commit_old", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      code_valid = 1'b0;
      repeat (3) step("hold", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      step("hold_ack", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
      step("hold_idle", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      ack_q.push_back(8'h5A);
      step("reaccept", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
      upd_req = 1'b0;
      settle_tail("reaccept", 8'h5A);

      // Scan beats parallel load: 5A shifted with si=1 gives B5.
      se_n = 1'b0; code_valid = 1'b1; d = 8'h00; si = 1'b1;
      step("prio", 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
      se_n = 1'b1; code_valid = 1'b0; si = 1'b0; upd_req = 1'b1;
      ack_q.push_back(8'hB5);
      step("prio_commit", 8'hB5, 1'b1, 1'b0, 1'b0, 1'b0);
      upd_req = 1'b0;
      settle_tail("prio", 8'hB5);

      // Reset during settle aborts the commit without an ack.
      code_valid = 1'b1; d = 8'hC3;
      step("abort_load", 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0);
      code_valid = 1'b0; upd_req = 1'b1;
      step("abort_commit", 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
      upd_req = 1'b0;
      step("abort_settle", 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort.q", 64'(q), 64'h0);
      chk("abort.busy", 64'(busy), 64'h0);
      chk("abort.ack", 64'(upd_ack), 64'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      load_commit("post_rst", 8'h66, 8'h00);

      // Parity vectors (q_par compared when the option is built in).
      load_commit("par07", 8'h07, 8'h66);
      load_commit("par03", 8'h03, 8'h07);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 64'(sb.size()), 64'h0);
      chk("acks_missing", 64'(ack_q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aibnd_str_reg.md
AIBND_STR_REG -- requirements
Module: aibnd_str_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the code register, legal range 2..64.
REQ-002 SHALL have parameter SETTLE_CYC, default 4: number of settle cycles after a commit, legal range 1..255.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-high.
REQ-005 SHALL have port se_n  input  1  scan enable, active-low; 0 selects shift mode.
REQ-006 SHALL have port si  input  1  scan serial in.
REQ-007 SHALL have port so  output  1  scan serial out, equal to stg[WIDTH-1].
REQ-008 SHALL have port code_valid  input  1  parallel load strobe for the staging register.
REQ-009 SHALL have port d  input  WIDTH  parallel code data.
REQ-010 SHALL have port upd_req  input  1  commit request, staging to active.
REQ-011 SHALL have port upd_ack  output  1  one-cycle pulse marking the end of settling.
REQ-012 SHALL have port busy  output  1  high while a commit is settling or acknowledging.
REQ-013 SHALL have port q  output  WIDTH  active code, driven directly from the active register.

Function
REQ-014 The staging register stg SHALL update as follows: se_n=0 gives stg <= {stg[WIDTH-2:0], si}; se_n=1 with code_valid=1 gives stg <= d; otherwise stg holds.
REQ-015 Scan SHALL take priority over code_valid when both are active.
REQ-016 The update FSM SHALL have three states: IDLE, SETTLE and ACK.
REQ-017 In IDLE, upd_req=1 SHALL commit the register: q <= stg (the pre-edge value), cnt <= SETTLE_CYC-1, next state SETTLE.
REQ-018 In SETTLE, the FSM SHALL decrement cnt each cycle and move to ACK on the edge where cnt==0.
REQ-019 In ACK, upd_ack SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 Latency SHALL be fixed: upd_req sampled at edge n gives q updated after edge n, busy=1 in cycles n+1 .. n+SETTLE_CYC+1, and upd_ack=1 in cycle n+SETTLE_CYC+1 only.
REQ-021 busy SHALL be registered state decode, equal to (state != IDLE).
REQ-022 upd_req SHALL be ignored in SETTLE and ACK; it is not queued.
REQ-023 upd_req held high SHALL be accepted again on the first IDLE cycle after ACK.
REQ-024 stg SHALL keep loading and shifting while busy; q SHALL change only at a commit.
REQ-025 A simultaneous commit and stg load SHALL commit the old stg; the new stg value is kept for the next commit.
REQ-026 The cnt width SHALL be clog2(SETTLE_CYC+1) and the counter SHALL never wrap.

Reset
REQ-027 On rst=1, stg, q and cnt SHALL clear to 0 asynchronously.
REQ-028 On rst=1, the state SHALL go to IDLE and busy and upd_ack SHALL be 0.
REQ-029 Reset asserted mid-settle SHALL abort the commit with no upd_ack.
REQ-030 Reset deassertion SHALL be synchronous to clk; the first edge after release SHALL behave as IDLE.

Configuration
REQ-031 Macro AIBND_STR_REG_PARITY_EN defined SHALL add output q_par  1: registered even parity of q.
REQ-032 With the macro defined, q_par SHALL update on the same edge as q and reset to 0.
REQ-033 Macro absent SHALL mean no q_par port and no parity logic; all other behaviour is identical.

Verification
REQ-034 Bench SHALL cover: WIDTH=8, se_n=0, shift in 8'hA5 MSB-first over 8 clocks -> stg=8'hA5; so during the next 8 shift clocks = 1,0,1,0,0,1,0,1.
REQ-035 Bench SHALL cover: code_valid=1, d=8'h3C, then upd_req pulse at edge n -> q=8'h3C after edge n; busy for 5 cycles; upd_ack only in cycle n+5 (SETTLE_CYC=4).
REQ-036 Bench SHALL cover: upd_req re-pulsed at n+2 with stg=8'hFF -> ignored, q stays 8'h3C, a single upd_ack.
REQ-037 Bench SHALL cover: se_n=0 and code_valid=1 together with si=1 -> shift wins, d is discarded.
REQ-038 Bench SHALL cover: rst pulsed at n+2 of a commit -> busy=0 and q=0 immediately, no upd_ack, next upd_req accepted.
REQ-039 Bench SHALL cover: macro defined, commit of 8'h07 -> q_par=1; commit of 8'h03 -> q_par=0.
